ps2_scan_decoder: RTL and testbench

Receives PS/2 keyboard frames on the ps2_clk/ps2_data pins and decodes the set-2 make, break and E0 prefix sequences. Holds the most recent make code on `scan`, which drives the note-rendering VGA stage downstream (0x23..0x21 = notes, 0x76 = ESC blank). Runs entirely in the clk_100MHz domain and oversamples the slow PS/2 clock.

---
 rtl/ps2_scan_decoder.sv | 186 ++++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_scan_decoder
// Brief    : PS/2 set-2 receiver with make/break/E0 decode for the note display.
//            Optional macro PS2_RELEASE_CLEAR_EN: a matching release blanks scan.
// Revision : 1.0  initial release
// ============================================================================
module ps2_scan_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan,
  output logic       scan_ext,
  output logic       scan_valid,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       frame_err
);

  localparam int                c_FC_W    = $clog2(FILTER_LEN + 1);
  localparam int                c_WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_FC_W-1:0] c_FC_LAST = c_FC_W'(FILTER_LEN - 1);
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_clk_sync, r_dat_sync;
  logic              w_clk_s, w_dat_s;
  logic              r_filt, r_fall;
  logic [c_FC_W-1:0] r_fcnt;
  logic [c_WD_W-1:0] r_wd;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift, r_rx_byte, r_scan;
  logic              r_parity, r_rx_strobe, r_frame_err;
  logic              r_scan_ext, r_scan_valid, r_ext_pend, r_brk_pend;
  logic              w_shift_en, w_par_en, w_good, w_err, w_timeout;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_clk_sync <= '0;
      r_dat_sync <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_data};
    end
  end

  assign w_clk_s = r_clk_sync[1];
  assign w_dat_s = r_dat_sync[1];

  // Level flips only once the synced clock disagrees for FILTER_LEN samples in a row
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_filt <= 1'b1;
      r_fcnt <= '0;
      r_fall <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (w_clk_s == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == c_FC_LAST) begin
        r_filt <= w_clk_s;
        r_fcnt <= '0;
        r_fall <= r_filt;
      end else begin
        r_fcnt <= r_fcnt + c_FC_W'(1);
      end
    end
  end

  assign w_timeout = (r_state != S_IDLE) && (r_wd == c_WD_LAST);

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_good      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: if (r_fall) begin
        if (!w_dat_s) w_state_nxt = S_DATA;
        else          w_err       = 1'b1;
      end
      S_DATA: if (r_fall) begin
        w_shift_en = 1'b1;
        if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
      end
      S_PARITY: if (r_fall) begin
        w_par_en    = 1'b1;
        w_state_nxt = S_STOP;
      end
      S_STOP: if (r_fall) begin
        w_state_nxt = S_IDLE;
        if (w_dat_s && (^{r_shift, r_parity})) w_good = 1'b1;
        else                                   w_err  = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A fall in the expiry cycle wins; the timeout only fires without one
    if (!r_fall && w_timeout) begin
      w_err       = 1'b1;
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_wd        <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_rx_byte   <= '0;
      r_rx_strobe <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (r_state == S_IDLE || r_fall) r_wd <= '0;
      else if (r_wd != c_WD_LAST)      r_wd <= r_wd + c_WD_W'(1);
      if (r_state == S_IDLE) r_bit_cnt <= '0;
      else if (w_shift_en)   r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_shift_en) r_shift  <= {w_dat_s, r_shift[7:1]};
      if (w_par_en)   r_parity <= w_dat_s;
      if (w_good)     r_rx_byte <= r_shift;
      r_rx_strobe <= w_good;
      r_frame_err <= w_err;
    end
  end

  // Decode consumes the byte in the same cycle it is latched into rx_byte
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_scan       <= '0;
      r_scan_ext   <= 1'b0;
      r_scan_valid <= 1'b0;
      r_ext_pend   <= 1'b0;
      r_brk_pend   <= 1'b0;
    end else begin
      r_scan_valid <= 1'b0;
      if (w_good) begin
        if (r_shift == 8'hE0) begin
          r_ext_pend <= 1'b1;
        end else if (r_shift == 8'hF0) begin
          r_brk_pend <= 1'b1;
        end else if (r_brk_pend) begin
          r_brk_pend <= 1'b0;
          r_ext_pend <= 1'b0;
`ifdef PS2_RELEASE_CLEAR_EN
          if (r_shift == r_scan && r_ext_pend == r_scan_ext) begin
            r_scan       <= 8'h00;
            r_scan_ext   <= 1'b0;
            r_scan_valid <= 1'b1;
          end
`endif
        end else begin
          r_scan       <= r_shift;
          r_scan_ext   <= r_ext_pend;
          r_ext_pend   <= 1'b0;
          r_scan_valid <= 1'b1;
        end
      end
    end
  end

  assign scan       = r_scan;
  assign scan_ext   = r_scan_ext;
  assign scan_valid = r_scan_valid;
  assign rx_byte    = r_rx_byte;
  assign rx_strobe  = r_rx_strobe;
  assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ps2_scan_decoder
// Brief    : Self-checking bench: directed and random PS/2 frames vs a key model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ps2_scan_decoder;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int HALF           = 40;

  logic       clk_100MHz = 1'b0;
  logic       reset      = 1'b1;
  logic       ps2_clk    = 1'b1;
  logic       ps2_data   = 1'b1;
  logic [7:0] scan, rx_byte;
  logic       scan_ext, scan_valid, rx_strobe, frame_err;

  ps2_scan_decoder #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_dut (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scan      (scan),
    .scan_ext  (scan_ext),
    .scan_valid(scan_valid),
    .rx_byte   (rx_byte),
    .rx_strobe (rx_strobe),
    .frame_err (frame_err)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, last_err_cyc = 0, last_drive_cyc = 0;
  int mon_strobe = 0, mon_err = 0, mon_valid = 0, mon_orphan = 0;

  // Reference key state, updated from the bytes the bench sends
  logic [7:0] m_scan = 8'h00, m_rx = 8'h00;
  logic       m_ext = 1'b0, m_epend = 1'b0, m_bpend = 1'b0;
  int         exp_strobe = 0, exp_err = 0, exp_valid = 0;

  always @(posedge clk_100MHz) cyc++;

  always @(negedge clk_100MHz) begin
    if (rx_strobe) mon_strobe++;
    if (scan_valid) mon_valid++;
    if (scan_valid && !rx_strobe) mon_orphan++;
    if (frame_err) begin
      mon_err++;
      last_err_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_100MHz);
    #1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_epend = 1'b1;
    else if (b == 8'hF0) m_bpend = 1'b1;
    else if (m_bpend) begin
`ifdef PS2_RELEASE_CLEAR_EN
      if (b == m_scan && m_epend == m_ext) begin
        m_scan = 8'h00;
        m_ext  = 1'b0;
        exp_valid++;
      end
`endif
      m_bpend = 1'b0;
      m_epend = 1'b0;
    end else begin
      m_scan  = b;
      m_ext   = m_epend;
      m_epend = 1'b0;
      exp_valid++;
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF / 2);
    ps2_clk = 1'b0;
    last_drive_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    wait_cyc(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic [7:0] v;
    v = b;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(v[i]);
    ps2_bit((~^v) ^ bad_par);
    ps2_bit(~bad_stop);
    ps2_data = 1'b1;
    wait_cyc(30);
    if (bad_par || bad_stop) exp_err++;
    else begin
      exp_strobe++;
      m_rx = b;
      model_byte(b);
    end
  endtask

  task automatic check_state(input string tag);
    check($sformatf("%s.rx_byte", tag),  {24'd0, rx_byte}, {24'd0, m_rx});
    check($sformatf("%s.strobes", tag),  mon_strobe, exp_strobe);
    check($sformatf("%s.errs", tag),     mon_err, exp_err);
    check($sformatf("%s.scan", tag),     {24'd0, scan}, {24'd0, m_scan});
    check($sformatf("%s.scan_ext", tag), {31'd0, scan_ext}, {31'd0, m_ext});
    check($sformatf("%s.valids", tag),   mon_valid, exp_valid);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [7:0] codes [6];
    logic [7:0] b;
    int         e0, sel;
    codes = '{8'h1C, 8'h23, 8'h75, 8'h4B, 8'h76, 8'h21};

    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(20);
    check("rst.scan", {24'd0, scan}, 32'h0);
    check("rst.scan_ext", {31'd0, scan_ext}, 32'h0);
    check("rst.rx_byte", {24'd0, rx_byte}, 32'h0);
    check("rst.pulses", {29'd0, scan_valid, rx_strobe, frame_err}, 32'h0);

    send_frame(8'h23, 1'b0, 1'b0);
    check_state("make23");
    check("make23.const", {23'd0, scan_ext, scan}, 32'h023);

    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    check_state("e075");
    check("e075.const", {23'd0, scan_ext, scan}, 32'h175);
    send_frame(8'h1B, 1'b0, 1'b0);
    check("make1b.const", {23'd0, scan_ext, scan}, 32'h01B);

    send_frame(8'h4B, 1'b0, 1'b0);
    check("make4b.const", {24'd0, scan}, 32'h4B);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h4B, 1'b0, 1'b0);
    check_state("rel4b");
`ifdef PS2_RELEASE_CLEAR_EN
    check("rel4b.const", {24'd0, scan}, 32'h00);
`else
    check("rel4b.const", {24'd0, scan}, 32'h4B);
`endif

    send_frame(8'h2D, 1'b1, 1'b0);
    check_state("bad_par");

    // Frame abandoned after four data bits; the bus then idles high
    e0 = mon_err;
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    ps2_data = 1'b1;
    for (int k = 0; k < TIMEOUT_CYCLES + 200 && mon_err == e0; k++) wait_cyc(1);
    wait_cyc(300);
    exp_err++;
    check("timeout.count", mon_err - e0, 1);
    check("timeout.latency_ok",
          {31'd0, (last_err_cyc - last_drive_cyc >= TIMEOUT_CYCLES) &&
                  (last_err_cyc - last_drive_cyc <= TIMEOUT_CYCLES + FILTER_LEN + 8)}, 32'd1);
    check_state("timeout");
    send_frame(8'h3A, 1'b0, 1'b0);
    check_state("after_to");
    check("after_to.const", {24'd0, scan}, 32'h3A);

    for (int g = 0; g < 5; g++) begin
      ps2_clk = 1'b0;
      wait_cyc(FILTER_LEN / 2);
      ps2_clk = 1'b1;
      wait_cyc(20);
    end
    check_state("glitch");

    // Pending E0 and a partial frame are both discarded by reset
    send_frame(8'hE0, 1'b0, 1'b0);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    m_scan = 8'h00; m_ext = 1'b0; m_epend = 1'b0; m_bpend = 1'b0; m_rx = 8'h00;
    wait_cyc(50);
    check_state("midrst");
    check("midrst.const", {24'd0, scan}, 32'h00);
    send_frame(8'h1C, 1'b0, 1'b0);
    check_state("post_rst");
    check("post_rst.const", {23'd0, scan_ext, scan}, 32'h01C);

    for (int r = 0; r < 30; r++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2)       b = 8'hE0;
      else if (sel < 4)  b = 8'hF0;
      else if (sel == 4) b = m_scan;
      else if (sel == 5) b = 8'($urandom_range(1, 255));
      else               b = codes[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) send_frame(b, $urandom_range(0, 1) == 1, 1'b1);
      else if ($urandom_range(0, 9) == 0) send_frame(b, 1'b1, 1'b0);
      else send_frame(b, 1'b0, 1'b0);
      check_state($sformatf("rnd%0d", r));
    end

    check("valid_with_strobe", mon_orphan, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
